// File: rtl/leaf_pkt_pkg.sv
// Shared packet layout, FSM states and packet assembly for the leaf transmit path.
// Packet: [48] valid | [47:43] leaf | [42:39] port | [38:32] remote BRAM address | [31:0] payload.
package leaf_pkt_pkg;

    localparam int unsigned PAYLOAD_W        = 32;
    localparam int unsigned LEAF_W           = 5;
    localparam int unsigned PORT_W           = 4;
    localparam int unsigned ADDR_W           = 7;
    localparam int unsigned PKT_BITS         = 1 + LEAF_W + PORT_W + ADDR_W + PAYLOAD_W;
    localparam int unsigned FREESPACE_UPDATE = 64;

    localparam int unsigned PAYLOAD_LSB = 0;
    localparam int unsigned ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_W;
    localparam int unsigned PORT_LSB    = ADDR_LSB + ADDR_W;
    localparam int unsigned LEAF_LSB    = PORT_LSB + PORT_W;
    localparam int unsigned VALID_BIT   = LEAF_LSB + LEAF_W;

    typedef enum logic [1:0] {
        ST_UNCFG,
        ST_RUN,
        ST_HOLD,
        ST_NOCRED
    } state_t;

    function automatic logic [PKT_BITS-1:0] make_packet(
        input logic [LEAF_W-1:0]    leaf,
        input logic [PORT_W-1:0]    port,
        input logic [ADDR_W-1:0]    addr,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [PKT_BITS-1:0] pkt;
        pkt                           = '0;
        pkt[VALID_BIT]                = 1'b1;
        pkt[LEAF_LSB +: LEAF_W]       = leaf;
        pkt[PORT_LSB +: PORT_W]       = port;
        pkt[ADDR_LSB +: ADDR_W]       = addr;
        pkt[PAYLOAD_LSB +: PAYLOAD_W] = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/leaf_credit_counter.sv
// Credit counter: adds INC_SIZE on inc, subtracts one on dec, saturates at MAX_COUNT
// and raises a sticky overflow flag whenever saturation was needed.
module leaf_credit_counter #(
    parameter int unsigned CNT_BITS  = 8,
    parameter int unsigned MAX_COUNT = 128,
    parameter int unsigned INC_SIZE  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] count,
    output logic [CNT_BITS-1:0] count_next,
    output logic                overflow
);

    localparam int unsigned SUM_BITS = CNT_BITS + 2;

    logic [CNT_BITS-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [SUM_BITS-1:0] sum;
    logic                dec_eff;

    always_comb begin
        // a lone decrement at zero would wrap into a bogus saturation; never let it through
        dec_eff = dec && (inc || (count_q != '0));
        sum     = SUM_BITS'(count_q)
                + (inc     ? SUM_BITS'(INC_SIZE) : '0)
                - (dec_eff ? SUM_BITS'(1)        : '0);
        if (sum > SUM_BITS'(MAX_COUNT)) begin
            count_d    = CNT_BITS'(MAX_COUNT);
            overflow_d = 1'b1;
        end else begin
            count_d    = sum[CNT_BITS-1:0];
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= CNT_BITS'(MAX_COUNT);
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign overflow   = overflow_q;

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Leaf transmit path: wraps user words into BFT packets with destination and a wrapping
// remote write address, through a 1-deep output register gated by remote credits.
module leaf_stream_packetizer
    import leaf_pkt_pkg::*;
#(
    parameter int unsigned PACKET_BITS           = PKT_BITS,
    parameter int unsigned PAYLOAD_BITS          = PAYLOAD_W,
    parameter int unsigned NUM_LEAF_BITS         = LEAF_W,
    parameter int unsigned NUM_PORT_BITS         = PORT_W,
    parameter int unsigned NUM_ADDR_BITS         = ADDR_W,
    parameter int unsigned FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE
) (
    input  logic                     clk_user,
    input  logic                     reset,
    input  logic                     cfg_vld,
    input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_port,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    input  logic                     credit_update,
    input  logic                     bft_ready,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    output logic                     credit_overflow
);

    state_t                   state_q, state_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic [NUM_LEAF_BITS-1:0] dest_leaf_q, dest_leaf_d;
    logic [NUM_PORT_BITS-1:0] dest_port_q, dest_port_d;
    logic [NUM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [NUM_ADDR_BITS:0]   credits, credits_next;

    logic out_full;
    logic transfer;
    logic cfg_accept;
    logic ack;

    assign out_full   = dout_q[VALID_BIT];
    assign transfer   = vld_user2interface && ack;
    assign cfg_accept = cfg_vld && ((state_q == ST_UNCFG) || !out_full);

    leaf_credit_counter #(
        .CNT_BITS  (NUM_ADDR_BITS + 1),
        .MAX_COUNT (2 ** NUM_ADDR_BITS),
        .INC_SIZE  (FREESPACE_UPDATE_SIZE)
    ) u_credit (
        .clk        (clk_user),
        .rst_n      (reset),
        .inc        (credit_update),
        .dec        (transfer),
        .count      (credits),
        .count_next (credits_next),
        .overflow   (credit_overflow)
    );

    // State register
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            state_q <= ST_UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: after configuration the state simply tracks output-register occupancy
    // and whether credits will be exhausted once this cycle's send/update are applied.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_UNCFG: begin
                if (cfg_vld) state_d = ST_RUN;
            end
            default: begin
                if (transfer || (out_full && !bft_ready)) state_d = ST_HOLD;
                else if (credits_next == '0)              state_d = ST_NOCRED;
                else                                      state_d = ST_RUN;
            end
        endcase
    end

    // Outputs: accept uses registered credits, so an update only helps from the next cycle.
    always_comb begin
        ack = (state_q != ST_UNCFG)
           && (credits != '0)
           && ((state_q != ST_HOLD) || bft_ready);
    end

    assign ack_interface2user      = ack;
    assign dout_leaf_interface2bft = dout_q;

    always_comb begin
        dout_d      = dout_q;
        wr_addr_d   = wr_addr_q;
        dest_leaf_d = dest_leaf_q;
        dest_port_d = dest_port_q;

        if (transfer) begin
            dout_d = make_packet(dest_leaf_q, dest_port_q, wr_addr_q, din_leaf_user2interface);
        end else if (out_full && bft_ready) begin
            dout_d = '0;
        end

        if (cfg_accept) begin
            dest_leaf_d = cfg_leaf;
            dest_port_d = cfg_port;
            wr_addr_d   = '0;
        end else if (transfer) begin
            wr_addr_d = wr_addr_q + NUM_ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            dout_q      <= '0;
            wr_addr_q   <= '0;
            dest_leaf_q <= '0;
            dest_port_q <= '0;
        end else begin
            dout_q      <= dout_d;
            wr_addr_q   <= wr_addr_d;
            dest_leaf_q <= dest_leaf_d;
            dest_port_q <= dest_port_d;
        end
    end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Bench for leaf_stream_packetizer: directed scenarios plus random traffic, each cycle
// compared against a cycle-level behavioural model of the packetizer rules.
module tb_leaf_stream_packetizer;
    import leaf_pkt_pkg::*;

    logic        clk_user = 1'b0;
    logic        reset;
    logic        cfg_vld;
    logic [4:0]  cfg_leaf;
    logic [3:0]  cfg_port;
    logic [31:0] din;
    logic        vld;
    logic        ack;
    logic        credit_update;
    logic        bft_ready;
    logic [48:0] dout;
    logic        credit_overflow;

    always #5 clk_user = ~clk_user;

    leaf_stream_packetizer dut (
        .clk_user                (clk_user),
        .reset                   (reset),
        .cfg_vld                 (cfg_vld),
        .cfg_leaf                (cfg_leaf),
        .cfg_port                (cfg_port),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .credit_update           (credit_update),
        .bft_ready               (bft_ready),
        .dout_leaf_interface2bft (dout),
        .credit_overflow         (credit_overflow)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Behavioural model state
    bit          m_cfgd;
    bit          m_full;
    logic [48:0] m_pkt;
    int          m_credits;
    int          m_addr;
    bit          m_ovf;
    logic [4:0]  m_leaf;
    logic [3:0]  m_port;
    bit          obs_ack;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cfgd    = 1'b0;
        m_full    = 1'b0;
        m_pkt     = '0;
        m_credits = 128;
        m_addr    = 0;
        m_ovf     = 1'b0;
        m_leaf    = '0;
        m_port    = '0;
    endtask

    // One clock: drive inputs, check ack mid-cycle, advance model, check registered outputs.
    task automatic cycle(input bit v, input logic [31:0] data, input bit cu, input bit rdy,
                         input bit cfg, input logic [4:0] leaf, input logic [3:0] port);
        bit exp_ack, xfer, cfg_ok;
        vld = v; din = data; credit_update = cu; bft_ready = rdy;
        cfg_vld = cfg; cfg_leaf = leaf; cfg_port = port;
        @(negedge clk_user);
        exp_ack = m_cfgd && (m_credits > 0) && (!m_full || rdy);
        obs_ack = ack;
        check("ack", {63'd0, ack}, {63'd0, exp_ack});
        xfer   = v && exp_ack;
        cfg_ok = cfg && (!m_cfgd || !m_full);
        if (xfer) begin
            m_pkt  = {1'b1, m_leaf, m_port, 7'(m_addr), data};
            m_full = 1'b1;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        m_credits = m_credits + (cu ? 64 : 0) - (xfer ? 1 : 0);
        if (m_credits > 128) begin
            m_credits = 128;
            m_ovf     = 1'b1;
        end
        if (cfg_ok) begin
            m_addr = 0;
            m_leaf = leaf;
            m_port = port;
            m_cfgd = 1'b1;
        end else if (xfer) begin
            m_addr = (m_addr + 1) % 128;
        end
        @(posedge clk_user);
        #1;
        if (m_full) check("dout", {15'd0, dout}, {15'd0, m_pkt});
        else        check("dout_valid", {63'd0, dout[48]}, 64'd0);
        check("credits", 64'(dut.u_credit.count_q), 64'(m_credits));
        check("overflow", {63'd0, credit_overflow}, {63'd0, m_ovf});
        cfg_vld = 1'b0;
        credit_update = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk_user);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int unsigned n_acc;
        logic [31:0] r;
        reset = 1'b1; cfg_vld = 1'b0; cfg_leaf = '0; cfg_port = '0;
        din = '0; vld = 1'b1; credit_update = 1'b0; bft_ready = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk_user);
        #1;
        check("rst_dout", {15'd0, dout}, 64'd0);
        check("rst_ack", {63'd0, ack}, 64'd0);
        check("rst_ovf", {63'd0, credit_overflow}, 64'd0);
        check("rst_credits", 64'(dut.u_credit.count_q), 64'd128);
        check("rst_state", 64'(dut.state_q), 64'(ST_UNCFG));
        reset = 1'b1;

        // Words offered before configuration are ignored
        repeat (2) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd5, 4'd3);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, '0, '0);
        check("first_packet", {15'd0, dout}, 64'h1_2980_DEAD_BEEF);
        check("first_credits", 64'(dut.u_credit.count_q), 64'd127);

        // Stream until credits run out
        n_acc = 0;
        repeat (130) begin
            cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, '0, '0);
            n_acc += obs_ack;
        end
        check("stream_accepts", 64'(n_acc), 64'd127);
        check("nocred_state", 64'(dut.state_q), 64'(ST_NOCRED));

        // Update arrives while offering: no ack yet, then addr 0 with 63 credits left
        cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0, '0, '0);
        check("nocred_ack_blocked", {63'd0, obs_ack}, 64'd0);
        cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, '0, '0);
        check("resume_ack", {63'd0, obs_ack}, 64'd1);
        check("wrapped_addr", {57'd0, dout[38:32]}, 64'd0);
        check("resume_credits", 64'(dut.u_credit.count_q), 64'd63);

        // Back-pressure holds the registered packet
        repeat (5) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);
        check("hold_state", 64'(dut.state_q), 64'(ST_HOLD));
        cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, '0, '0);
        check("release_accept", {63'd0, obs_ack}, 64'd1);

        // Update at full credits saturates and flags overflow
        apply_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd9, 4'd1);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
        check("sat_ovf", {63'd0, credit_overflow}, 64'd1);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        check("ovf_sticky", {63'd0, credit_overflow}, 64'd1);

        // Send + update together at 100 credits: 163 saturates to 128
        apply_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd17, 4'd12);
        repeat (28) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, '0, '0);
        check("credits_100", 64'(dut.u_credit.count_q), 64'd100);
        check("no_ovf_yet", {63'd0, credit_overflow}, 64'd0);
        cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0, '0, '0);
        check("sat_163", 64'(dut.u_credit.count_q), 64'd128);
        check("sat_163_ovf", {63'd0, credit_overflow}, 64'd1);

        // Asynchronous reset while holding a packet
        apply_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd2, 4'd7);
        cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);
        vld = 1'b1; bft_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_dout", {15'd0, dout}, 64'd0);
        check("async_ack", {63'd0, ack}, 64'd0);
        @(posedge clk_user);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (3) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, '0, '0);
        check("post_rst_state", 64'(dut.state_q), 64'(ST_UNCFG));

        // Random traffic against the model
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 5'($urandom), 4'($urandom));
        repeat (600) begin
            r = $urandom;
            if (r[5:0] == 6'd0)
                cycle(1'b0, '0, 1'b0, r[6] | r[7], 1'b1, 5'($urandom), 4'($urandom));
            else
                cycle(r[8] | r[9], $urandom, (r[14:10] == 5'd0), (r[17:16] != 2'd0),
                      1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
